// File: rtl/tnn_pkg.sv
// Shared types and sizing helpers for the sequential TNN threshold neuron.
package tnn_pkg;

  typedef enum logic {ST_ACCUM, ST_DONE} tnn_state_t;

  // Worst-case |sum| is N_IN * (2**W_IN - 1); one extra bit carries the sign.
  function automatic int acc_width(input int n_in, input int w_in);
    return w_in + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/tnn_sign_acc.sv
// Signed accumulator with clear, enable and add/subtract select.
// acc_sum is the value the accumulator would take this cycle if enabled.
module tnn_sign_acc #(
  parameter int W_IN  = 3,
  parameter int ACC_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sub,
  input  logic [W_IN-1:0]         din,
  output logic signed [ACC_W-1:0] acc_sum
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] din_ext;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    din_ext = ACC_W'(din);
    acc_sum = sub ? (acc_q - din_ext) : (acc_q + din_ext);
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_sum;
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous, active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/tnn_seq_neuron.sv
// Sequential TNN threshold neuron: out_bit = (sum of first N_POS samples - sum of rest) > THRESH.
// Define TNN_MARGIN_OUT_EN to build the registered signed out_margin port.
module tnn_seq_neuron
  import tnn_pkg::*;
#(
  parameter  int N_IN   = 6,
  parameter  int W_IN   = 3,
  parameter  int N_POS  = 2,
  parameter  int THRESH = 0,
  localparam int ACC_W  = acc_width(N_IN, W_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_IN-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit
`ifdef TNN_MARGIN_OUT_EN
  ,
  output logic signed [ACC_W-1:0] out_margin
`endif
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic signed [ACC_W-1:0] THRESH_C = ACC_W'(THRESH);

  tnn_state_t              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_bit_q, out_bit_d;
  logic                    acc_en, acc_clr, acc_sub;
  logic signed [ACC_W-1:0] acc_sum;

  assign acc_sub = (idx_q >= IDX_W'(N_POS));

  tnn_sign_acc #(
    .W_IN  (W_IN),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (acc_en),
    .sub     (acc_sub),
    .din     (in_data),
    .acc_sum (acc_sum)
  );

`ifdef TNN_MARGIN_OUT_EN
  logic signed [ACC_W-1:0] margin_q, margin_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    in_ready    = 1'b0;
    acc_en      = 1'b0;
    acc_clr     = 1'b0;
`ifdef TNN_MARGIN_OUT_EN
    margin_d    = margin_q;
`endif
    unique case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        // acc_en gates everything, so in_data is never observed without a transfer.
        if (in_valid) begin
          acc_en = 1'b1;
          if (idx_q == IDX_W'(N_IN - 1)) begin
            acc_clr     = 1'b1;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_bit_d   = (acc_sum > THRESH_C);
`ifdef TNN_MARGIN_OUT_EN
            margin_d    = acc_sum - THRESH_C;
`endif
            state_d     = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
`ifdef TNN_MARGIN_OUT_EN
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
`ifdef TNN_MARGIN_OUT_EN
      margin_q    <= margin_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
`ifdef TNN_MARGIN_OUT_EN
  assign out_margin = margin_q;
`endif

endmodule
